// File: rtl/sseg_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_controller_pkg
// Description : Shared types and constants for the 4-digit seven-segment
//               scan controller. It holds the scan state encoding, the digit
//               count, the all-anodes-off pattern and the packed display
//               record.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_scan_controller_pkg;

    localparam int         N_DIGITS   = 4;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    // Scan state. OFF while disabled, GUARD for the anode-off lead-in of each
    // slot, ON while the current digit's anode may be driven.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

    // One complete display image. The staging and shadow registers both use it.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_data_t;

    // Selects nibble idx of a 16-bit value. Nibble 3 is [15:12].
    function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] idx);
        nibble_of = v[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : sseg_slot_timer
// Description : Digit-slot prescaler. It counts 0..CLK_DIV-1 while enabled and
//               wraps at the end. It returns to 0 whenever enable is low, so
//               every slot starts from count 0.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset
//               en       - count enable (low clears the count)
//               slot_cnt - current position inside the slot
//               slot_end - high on the last cycle of an enabled slot
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_slot_timer
    import sseg_scan_controller_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic [$clog2(CLK_DIV)-1:0] slot_cnt,
    output logic                       slot_end
);

    localparam int               CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign slot_cnt = r_cnt;
    assign slot_end = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/sseg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_controller
// Description : Time-multiplexed scan controller for a 4-digit common-anode
//               seven-segment display. Each digit gets CLK_DIV cycles. The
//               first GUARD cycles of a slot keep every anode off to suppress
//               ghosting. New data is staged and applied only at a frame
//               boundary, or at once while the scan is disabled. The
//               hex-to-7seg decoder sits outside this block and is driven by
//               digit_hex and digit_dp.
// Ports       : clk          - clock
//               rst          - asynchronous active-high reset
//               en           - scan enable
//               load         - one-cycle strobe; captures value/dp_in/blank_in
//               value        - four hex nibbles; [15:12] is digit 3 (MSD)
//               dp_in        - decimal point per digit
//               blank_in     - forced blank per digit
//               digit_hex    - nibble for the decoder Hex input
//               digit_dp     - decimal point for the decoder DP input
//               an           - active-low anode enables; an[i] drives digit i
//               frame_done   - one-cycle pulse on the last cycle of a frame
//               load_pending - staged data not yet applied to the display
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_controller
    import sseg_scan_controller_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 16,
    parameter int LZB     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  digit_hex,
    output logic        digit_dp,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        load_pending
);

    localparam int               CNT_W          = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] c_slot_last    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_slot_prelast = CNT_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] c_guard_last   = CNT_W'(GUARD - 1);
    localparam logic [1:0]       c_last_digit   = 2'(N_DIGITS - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [CNT_W-1:0] w_slot_cnt;
    logic             w_slot_end;
    logic             w_cnt_en;
    logic [1:0]       r_digit;
    logic [1:0]       w_digit_nxt;

    disp_data_t       r_stage;
    disp_data_t       r_shadow;
    logic             r_pending;

    logic             w_boundary;
    logic             w_xfer;
    logic             w_capture;
    logic             w_frame_nxt;

    logic [3:1]       w_nib_zero;
    logic [3:0]       w_lz_mask;
    logic [3:0]       w_blank;
    logic [3:0]       w_an_nxt;

    logic [3:0]       r_an;
    logic [3:0]       r_hex;
    logic             r_dp;
    logic             r_frame_done;

    // ------------------------------------------------------------------------
    // Slot timing. The counter runs only while the scan is active, so the
    // first cycle after leaving OFF is always slot count 0 of digit 0.
    // ------------------------------------------------------------------------
    assign w_cnt_en = en && (r_state != ST_OFF);

    sseg_slot_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_slot_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (w_cnt_en),
        .slot_cnt (w_slot_cnt),
        .slot_end (w_slot_end)
    );

    always_comb begin
        w_digit_nxt = r_digit;
        if (!w_cnt_en) begin
            w_digit_nxt = 2'd0;
        end else if (w_slot_end) begin
            w_digit_nxt = r_digit + 2'd1;
        end
    end

    // Last cycle of digit 3. Staged data moves to the shadow register on this
    // edge, or on any edge while the scan is off.
    assign w_boundary = (r_state != ST_OFF) && (r_digit == c_last_digit)
                        && (w_slot_cnt == c_slot_last);
    assign w_xfer     = r_pending && (w_boundary || (r_state == ST_OFF));

    // frame_done is registered. Assert it on the edge that enters the boundary
    // cycle, so the pulse lines up exactly with that cycle.
    assign w_frame_nxt = w_cnt_en && (r_digit == c_last_digit)
                         && (w_slot_cnt == c_slot_prelast);

    // The decoder inputs are latched in the first guard cycle. The shadow
    // register has already taken any frame-boundary update by then, so digit 0
    // of a new frame shows the new data.
    assign w_capture = (r_state == ST_GUARD) && (w_slot_cnt == '0);

    // ------------------------------------------------------------------------
    // Blanking: forced mask plus optional leading-zero suppression. Digit i>0
    // is a leading zero when nibbles 3..i are all zero. Digit 0 always shows.
    // ------------------------------------------------------------------------
    for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_nib_zero
        assign w_nib_zero[gi] = (r_shadow.value[gi*4 +: 4] == 4'd0);
    end

    always_comb begin
        w_lz_mask    = '0;
        w_lz_mask[3] = w_nib_zero[3];
        for (int i = 2; i >= 1; i--) begin
            w_lz_mask[i] = w_lz_mask[i+1] & w_nib_zero[i];
        end
    end

    if (LZB != 0) begin : g_lzb_on
        assign w_blank = r_shadow.blank | w_lz_mask;
    end else begin : g_lzb_off
        assign w_blank = r_shadow.blank;
    end

    // ------------------------------------------------------------------------
    // Scan state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = AN_ALL_OFF;
        if (!en) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:   w_state_nxt = ST_GUARD;
                ST_GUARD: if (w_slot_cnt == c_guard_last) w_state_nxt = ST_ON;
                ST_ON:    if (w_slot_end)                 w_state_nxt = ST_GUARD;
                default:  w_state_nxt = ST_OFF;
            endcase
        end
        // The digit index never changes on an edge that enters or stays in
        // ON, so the current index selects the next anode.
        if ((w_state_nxt == ST_ON) && !w_blank[r_digit]) begin
            w_an_nxt = ~(4'b0001 << r_digit);
        end
    end

    // ------------------------------------------------------------------------
    // Data path and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit      <= 2'd0;
            r_stage      <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_an         <= AN_ALL_OFF;
            r_hex        <= 4'd0;
            r_dp         <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_digit      <= w_digit_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_frame_nxt;

            if (load) begin
                r_stage <= {value, dp_in, blank_in};
            end
            // A load on a transfer edge stages new data behind the data being
            // transferred, so the pending flag stays set.
            if (w_xfer) begin
                r_shadow <= r_stage;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_xfer) begin
                r_pending <= 1'b0;
            end

            if (w_capture) begin
                r_hex <= nibble_of(r_shadow.value, r_digit);
                r_dp  <= r_shadow.dp[r_digit];
            end
        end
    end

    assign digit_hex    = r_hex;
    assign digit_dp     = r_dp;
    assign an           = r_an;
    assign frame_done   = r_frame_done;
    assign load_pending = r_pending;

endmodule
`default_nettype wire

// File: doc/sseg_scan_controller.md
SSEG_SCAN_CONTROLLER -- requirements
Module: sseg_scan_controller

Interface
REQ-001 Parameter CLK_DIV, default 50000: clock cycles per digit slot, legal range 4..2^20.
REQ-002 Parameter GUARD, default 16: anode-off cycles at the start of each slot, legal range 1..CLK_DIV-1.
REQ-003 Parameter LZB, default 1: when 1, leading-zero blanking is enabled.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port en, input, 1 bit: scan enable.
REQ-007 Port load, input, 1 bit: one-cycle strobe that captures value, dp_in and blank_in.
REQ-008 Port value, input, 16 bits: four hex nibbles; digit 3 is [15:12] and is most significant.
REQ-009 Port dp_in, input, 4 bits: decimal point per digit.
REQ-010 Port blank_in, input, 4 bits: forced-blank mask per digit.
REQ-011 Port digit_hex, output, 4 bits: nibble for the downstream hex-to-7seg decoder Hex input.
REQ-012 Port digit_dp, output, 1 bit: decimal point for the decoder DP input.
REQ-013 Port an, output, 4 bits: active-low anode enables; an[i] drives digit i.
REQ-014 Port frame_done, output, 1 bit: one-cycle pulse at the end of each full 4-digit frame.
REQ-015 Port load_pending, output, 1 bit: staged data not yet applied to display.

Function
REQ-016 The block SHALL hold a staging register and a shadow register, each {value, dp, blank}; the display SHALL read only the shadow register.
REQ-017 load=1 SHALL write the staging register and set load_pending=1 on the same edge; on back-to-back loads the last load wins.
REQ-018 The staging-to-shadow transfer SHALL occur only at a frame boundary: the cycle where digit index=3 and slot_cnt=CLK_DIV-1. On that edge load_pending SHALL clear.
REQ-019 If load coincides with a frame boundary, the previously staged data SHALL transfer, the new data SHALL be staged, and load_pending SHALL remain 1.
REQ-020 The state machine SHALL have three states:
 - OFF: en=0.
 - GUARD: slot_cnt<GUARD.
 - ON: slot_cnt>=GUARD.
REQ-021 State transitions SHALL be:
 - OFF->GUARD on en=1.
 - GUARD->ON when slot_cnt=GUARD-1.
 - ON->GUARD at slot end.
 - any state->OFF on en=0.
REQ-022 slot_cnt SHALL count 0..CLK_DIV-1 and wrap. At wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-023 In OFF, an SHALL be 4'b1111, and slot_cnt and digit index SHALL be held at 0. A pending load SHALL transfer to the shadow register on the next edge.
REQ-024 In GUARD, an SHALL be 4'b1111. digit_hex and digit_dp SHALL be registered from the shadow register for the current digit on the first GUARD cycle and held for the rest of the slot.
REQ-025 In ON, an[i] SHALL be 0 only for the current digit i, and only if that digit is not blanked.
REQ-026 Digit i SHALL be blanked if blank[i]=1, or if LZB=1, i>0, and shadow nibbles 3..i are all zero.
REQ-027 Digit 0 SHALL never be blanked by LZB.
REQ-028 frame_done SHALL be 1 for exactly the frame-boundary cycle of REQ-018, and 0 in OFF.
REQ-029 Outputs SHALL be registered, with zero combinational paths from inputs to outputs.
REQ-030 Frame length SHALL be exactly 4*CLK_DIV cycles.

Reset
REQ-031 When rst=1, the block SHALL asynchronously force:
 - an=4'b1111, digit_hex=0, digit_dp=0, frame_done=0, load_pending=0;
 - staging and shadow registers=0;
 - slot_cnt=0, digit index=0, state=OFF.
REQ-032 When rst is asserted mid-slot, an SHALL go to 1111 without waiting for a clock edge. After release the block SHALL enter GUARD of digit 0 on the first edge with en=1.

Structure
REQ-033 The shared package SHALL hold the state enum {OFF, GUARD, ON}, the constant N_DIGITS=4 and the constant AN_ALL_OFF=4'b1111.
REQ-034 The slot prescaler SHALL be the sub-module sseg_slot_timer (CLK_DIV parameter; outputs slot_cnt and slot_end). The hex-to-7seg decoder SHALL be instantiated by the parent, not inside this block.

Verification (CLK_DIV=8, GUARD=2, LZB=1)
REQ-035 Scenario 1: rst, then en=1 with load value=16'h1234, dp_in=0, blank_in=0.
 - In the ON cycles of successive slots, an SHALL read 1110, 1101, 1011, 0111 with digit_hex 4, 3, 2, 1.
 - frame_done SHALL pulse every 32 cycles.
REQ-036 Scenario 2: load 16'h0042 mid-frame.
 - Old data SHALL display until frame_done; load_pending SHALL be 1 until then.
 - The next frame SHALL show digits 3 and 2 with an bit high (blanked), and digits 1 and 0 SHALL show 4 and 2.
REQ-037 Scenario 3: value=16'h0000 -> only digit 0 lit, showing 0. Then blank_in=4'b0001 -> all anodes stay 1111.
REQ-038 Scenario 4: load asserted exactly on the frame-boundary cycle with 16'hABCD, with 16'h5555 already staged.
 - The next frame SHALL show 5555; load_pending SHALL stay 1.
 - The following frame SHALL show ABCD.
REQ-039 Scenario 5: en dropped during ON of digit 2 -> an=1111 on the next edge. en re-raised -> 2 guard cycles, then digit 0.
REQ-040 Scenario 6: rst asserted asynchronously between edges during ON -> an=1111 immediately; all outputs at reset values.
